// File: rtl/fll_channel_scheduler_pkg.sv
// Shared constants and types for the FLL channel scheduler.
//   NUM_CHANNELS   tracked channels
//   CHAN_W         channel tag width
//   ACC_W/IQ_W     prompt accumulation / magnitude widths
//   WDF_W/WDFDOT_W Doppler shift / rate widths
//   DINC_W         carrier NCO phase increment width
//   TIMEOUT_CYCLES longest wait for an FLL answer before aborting
package fll_channel_scheduler_pkg;

  localparam int NUM_CHANNELS   = 4;
  localparam int CHAN_W         = $clog2(NUM_CHANNELS);
  localparam int ACC_W          = 16;
  localparam int IQ_W           = 17;
  localparam int WDF_W          = 20;
  localparam int WDFDOT_W       = 16;
  localparam int DINC_W         = 24;
  localparam int TIMEOUT_CYCLES = 1024;
  localparam int TMR_W          = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DISPATCH  = 2'd1,
    ST_WAIT      = 2'd2,
    ST_WRITEBACK = 2'd3
  } sched_state_t;

endpackage

// File: rtl/fll_channel_scheduler_req_fifo.sv
// Request FIFO of channel tags awaiting dispatch to the FLL.
//   clk, reset          clock, synchronous active-high reset
//   push, push_tag      append a tag (ignored when full)
//   pop                 drop the head entry (ignored when empty)
//   inv, inv_tag        clear the valid bit of every entry holding inv_tag
//   empty               no entries stored
//   head_tag/head_valid oldest entry and whether it is still live
module fll_channel_scheduler_req_fifo
  import fll_channel_scheduler_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [CHAN_W-1:0] push_tag,
  input  logic              pop,
  input  logic              inv,
  input  logic [CHAN_W-1:0] inv_tag,
  output logic              empty,
  output logic [CHAN_W-1:0] head_tag,
  output logic              head_valid
);

  logic [CHAN_W-1:0]       tag_q [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] vld_q;
  logic [CHAN_W-1:0]       wr_ptr;
  logic [CHAN_W-1:0]       rd_ptr;
  logic [CHAN_W:0]         count;
  logic                    do_push;
  logic                    do_pop;

  function automatic logic [CHAN_W-1:0] ptr_inc(input logic [CHAN_W-1:0] p);
    return (p == CHAN_W'(NUM_CHANNELS - 1)) ? '0 : p + CHAN_W'(1);
  endfunction

  assign empty      = (count == '0);
  assign do_push    = push && (count != (CHAN_W + 1)'(NUM_CHANNELS));
  assign do_pop     = pop && !empty;
  assign head_tag   = tag_q[rd_ptr];
  assign head_valid = vld_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) tag_q[i] <= '0;
      vld_q  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // A seeded channel's queued request is stale; keep the slot so the
      // scheduler can drain it in order.
      if (inv) begin
        for (int i = 0; i < NUM_CHANNELS; i++) begin
          if (tag_q[i] == inv_tag) vld_q[i] <= 1'b0;
        end
      end
      if (do_pop) begin
        vld_q[rd_ptr] <= 1'b0;
        rd_ptr        <= ptr_inc(rd_ptr);
      end
      if (do_push) begin
        tag_q[wr_ptr] <= push_tag;
        vld_q[wr_ptr] <= 1'b1;
        wr_ptr        <= ptr_inc(wr_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (CHAN_W + 1)'(1);
        2'b01:   count <= count - (CHAN_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fll_channel_scheduler.sv
// Host side of the FLL channel-control interface. Keeps per-channel prompt
// history (periods k and k-1) and Doppler state, queues channels holding two
// samples, dispatches them one at a time to the FLL, writes the returned
// Doppler/rate back and forwards the phase increment to the carrier NCO.
//   clk, reset                    clock, synchronous active-high reset
//   acc_valid/tag/i/q/iq          accumulation dump for one channel
//   seed_valid/tag/wdf            (re)initialise a channel from acquisition
//   fll_start/tag + fll_*         one-cycle dispatch pulse and held snapshot
//   fll_done/done_tag + results   FLL answer (dinc, wdf_kp1, wdfdot_kp1)
//   dop_valid/tag/inc             one-cycle update to the carrier NCO
//   overrun                       sticky: dump for an already-queued channel
//   timeout_err                   sticky: FLL did not answer in time
//
// state        | meaning
// -------------+--------------------------------------------------------
// ST_IDLE      | drain invalid FIFO heads, start a dispatch on a live head
// ST_DISPATCH  | fll_start high, snapshot stable, pop head, clear pending
// ST_WAIT      | wait for fll_done with our tag, count down to timeout
// ST_WRITEBACK | store wdf/wdfdot, pulse dop_valid unless channel reseeded
module fll_channel_scheduler
  import fll_channel_scheduler_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                acc_valid,
  input  logic [CHAN_W-1:0]   acc_tag,
  input  logic [ACC_W-1:0]    acc_i,
  input  logic [ACC_W-1:0]    acc_q,
  input  logic [IQ_W-1:0]     acc_iq,
  input  logic                seed_valid,
  input  logic [CHAN_W-1:0]   seed_tag,
  input  logic [WDF_W-1:0]    seed_wdf,
  output logic                fll_start,
  output logic [CHAN_W-1:0]   fll_tag,
  output logic [ACC_W-1:0]    fll_i_k,
  output logic [ACC_W-1:0]    fll_q_k,
  output logic [ACC_W-1:0]    fll_i_km1,
  output logic [ACC_W-1:0]    fll_q_km1,
  output logic [IQ_W-1:0]     fll_iq_k,
  output logic [IQ_W-1:0]     fll_iq_km1,
  output logic [WDF_W-1:0]    fll_wdf_k,
  output logic [WDFDOT_W-1:0] fll_wdfdot_k,
  input  logic                fll_done,
  input  logic [CHAN_W-1:0]   fll_done_tag,
  input  logic [DINC_W-1:0]   fll_dinc,
  input  logic [WDF_W-1:0]    fll_wdf_kp1,
  input  logic [WDFDOT_W-1:0] fll_wdfdot_kp1,
  output logic                dop_valid,
  output logic [CHAN_W-1:0]   dop_tag,
  output logic [DINC_W-1:0]   dop_inc,
  output logic                overrun,
  output logic                timeout_err
);

  logic [ACC_W-1:0]        i_k_q    [NUM_CHANNELS];
  logic [ACC_W-1:0]        q_k_q    [NUM_CHANNELS];
  logic [ACC_W-1:0]        i_km1_q  [NUM_CHANNELS];
  logic [ACC_W-1:0]        q_km1_q  [NUM_CHANNELS];
  logic [IQ_W-1:0]         iq_k_q   [NUM_CHANNELS];
  logic [IQ_W-1:0]         iq_km1_q [NUM_CHANNELS];
  logic [WDF_W-1:0]        wdf_q    [NUM_CHANNELS];
  logic [WDFDOT_W-1:0]     wdfdot_q [NUM_CHANNELS];
  // hist_cnt saturates at 1: "one sample seen", the next dump completes a pair.
  logic [NUM_CHANNELS-1:0] hist_seen_q;
  logic [NUM_CHANNELS-1:0] pending_q;

  sched_state_t        st_q, st_d;
  logic [TMR_W-1:0]    tmr_q;
  logic                seed_hit_q;
  logic [WDF_W-1:0]    res_wdf_q;
  logic [WDFDOT_W-1:0] res_wdfdot_q;

  logic              fifo_empty;
  logic [CHAN_W-1:0] head_tag;
  logic              head_valid;
  logic              fifo_pop;
  logic              snap_load;
  logic              timeout_set;
  logic              wb_commit;

  logic acc_take, acc_pending, acc_push, acc_overrun;
  logic head_live, fwd, done_match, seed_hits_flight, wb_block;

  // Seed wins over a same-cycle dump for the same channel.
  assign acc_take    = acc_valid && !(seed_valid && (seed_tag == acc_tag));
  // The channel being dispatched this cycle is no longer pending, so a dump
  // arriving now queues a fresh request instead of counting as an overrun.
  assign acc_pending = pending_q[acc_tag] &&
                       !((st_q == ST_DISPATCH) && (fll_tag == acc_tag));
  assign acc_push    = acc_take && hist_seen_q[acc_tag] && !acc_pending;
  assign acc_overrun = acc_take && hist_seen_q[acc_tag] && acc_pending;

  // A head being invalidated this cycle is left for the drain path next cycle.
  assign head_live        = head_valid && !(seed_valid && (seed_tag == head_tag));
  // Snapshot is captured on the IDLE->DISPATCH edge; forward a dump that
  // lands in that same cycle so the FLL sees the latest sample.
  assign fwd              = acc_take && (acc_tag == head_tag);
  assign done_match       = fll_done && (fll_done_tag == fll_tag);
  assign seed_hits_flight = seed_valid && (seed_tag == fll_tag);
  assign wb_block         = seed_hit_q || seed_hits_flight;
  assign dop_tag          = fll_tag;

  fll_channel_scheduler_req_fifo u_req_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (acc_push),
    .push_tag   (acc_tag),
    .pop        (fifo_pop),
    .inv        (seed_valid),
    .inv_tag    (seed_tag),
    .empty      (fifo_empty),
    .head_tag   (head_tag),
    .head_valid (head_valid)
  );

  always_comb begin
    st_d        = st_q;
    fifo_pop    = 1'b0;
    snap_load   = 1'b0;
    fll_start   = 1'b0;
    timeout_set = 1'b0;
    wb_commit   = 1'b0;
    dop_valid   = 1'b0;
    case (st_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (head_live) begin
            snap_load = 1'b1;
            st_d      = ST_DISPATCH;
          end else if (!head_valid) begin
            fifo_pop = 1'b1;
          end
        end
      end
      ST_DISPATCH: begin
        fll_start = 1'b1;
        fifo_pop  = 1'b1;
        st_d      = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_match) begin
          st_d = ST_WRITEBACK;
        end else if (tmr_q == '0) begin
          timeout_set = 1'b1;
          st_d        = ST_IDLE;
        end
      end
      ST_WRITEBACK: begin
        wb_commit = !wb_block;
        dop_valid = !wb_block;
        st_d      = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        i_k_q[c]    <= '0;
        q_k_q[c]    <= '0;
        i_km1_q[c]  <= '0;
        q_km1_q[c]  <= '0;
        iq_k_q[c]   <= '0;
        iq_km1_q[c] <= '0;
        wdf_q[c]    <= '0;
        wdfdot_q[c] <= '0;
      end
      hist_seen_q <= '0;
      pending_q   <= '0;
    end else begin
      if (acc_take) begin
        i_km1_q[acc_tag]  <= i_k_q[acc_tag];
        q_km1_q[acc_tag]  <= q_k_q[acc_tag];
        iq_km1_q[acc_tag] <= iq_k_q[acc_tag];
        i_k_q[acc_tag]    <= acc_i;
        q_k_q[acc_tag]    <= acc_q;
        iq_k_q[acc_tag]   <= acc_iq;
        hist_seen_q[acc_tag] <= 1'b1;
      end
      if (st_q == ST_DISPATCH) pending_q[fll_tag] <= 1'b0;
      if (acc_push) pending_q[acc_tag] <= 1'b1;
      if (wb_commit) begin
        wdf_q[fll_tag]    <= res_wdf_q;
        wdfdot_q[fll_tag] <= res_wdfdot_q;
      end
      if (seed_valid) begin
        hist_seen_q[seed_tag] <= 1'b0;
        pending_q[seed_tag]   <= 1'b0;
        wdf_q[seed_tag]       <= seed_wdf;
        wdfdot_q[seed_tag]    <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q         <= ST_IDLE;
      tmr_q        <= '0;
      seed_hit_q   <= 1'b0;
      res_wdf_q    <= '0;
      res_wdfdot_q <= '0;
      fll_tag      <= '0;
      fll_i_k      <= '0;
      fll_q_k      <= '0;
      fll_i_km1    <= '0;
      fll_q_km1    <= '0;
      fll_iq_k     <= '0;
      fll_iq_km1   <= '0;
      fll_wdf_k    <= '0;
      fll_wdfdot_k <= '0;
      dop_inc      <= '0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      st_q <= st_d;

      if (snap_load) begin
        fll_tag      <= head_tag;
        fll_i_k      <= fwd ? acc_i  : i_k_q[head_tag];
        fll_q_k      <= fwd ? acc_q  : q_k_q[head_tag];
        fll_iq_k     <= fwd ? acc_iq : iq_k_q[head_tag];
        fll_i_km1    <= fwd ? i_k_q[head_tag]  : i_km1_q[head_tag];
        fll_q_km1    <= fwd ? q_k_q[head_tag]  : q_km1_q[head_tag];
        fll_iq_km1   <= fwd ? iq_k_q[head_tag] : iq_km1_q[head_tag];
        fll_wdf_k    <= wdf_q[head_tag];
        fll_wdfdot_k <= wdfdot_q[head_tag];
      end

      // A reseed after the snapshot makes the in-flight result stale.
      if (snap_load) begin
        seed_hit_q <= 1'b0;
      end else if (((st_q == ST_DISPATCH) || (st_q == ST_WAIT)) && seed_hits_flight) begin
        seed_hit_q <= 1'b1;
      end

      if (st_q == ST_DISPATCH) begin
        tmr_q <= TMR_W'(TIMEOUT_CYCLES - 1);
      end else if ((st_q == ST_WAIT) && (tmr_q != '0)) begin
        tmr_q <= tmr_q - TMR_W'(1);
      end

      if ((st_q == ST_WAIT) && done_match) begin
        dop_inc      <= fll_dinc;
        res_wdf_q    <= fll_wdf_kp1;
        res_wdfdot_q <= fll_wdfdot_kp1;
      end

      if (acc_overrun) overrun <= 1'b1;
      if (timeout_set) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fll_channel_scheduler.sv
module tb_fll_channel_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        acc_valid;
  logic [1:0]  acc_tag;
  logic [15:0] acc_i, acc_q;
  logic [16:0] acc_iq;
  logic        seed_valid;
  logic [1:0]  seed_tag;
  logic [19:0] seed_wdf;
  logic        fll_start;
  logic [1:0]  fll_tag;
  logic [15:0] fll_i_k, fll_q_k, fll_i_km1, fll_q_km1;
  logic [16:0] fll_iq_k, fll_iq_km1;
  logic [19:0] fll_wdf_k;
  logic [15:0] fll_wdfdot_k;
  logic        fll_done;
  logic [1:0]  fll_done_tag;
  logic [23:0] fll_dinc;
  logic [19:0] fll_wdf_kp1;
  logic [15:0] fll_wdfdot_kp1;
  logic        dop_valid;
  logic [1:0]  dop_tag;
  logic [23:0] dop_inc;
  logic        overrun;
  logic        timeout_err;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fll_channel_scheduler dut (
    .clk            (clk),
    .reset          (reset),
    .acc_valid      (acc_valid),
    .acc_tag        (acc_tag),
    .acc_i          (acc_i),
    .acc_q          (acc_q),
    .acc_iq         (acc_iq),
    .seed_valid     (seed_valid),
    .seed_tag       (seed_tag),
    .seed_wdf       (seed_wdf),
    .fll_start      (fll_start),
    .fll_tag        (fll_tag),
    .fll_i_k        (fll_i_k),
    .fll_q_k        (fll_q_k),
    .fll_i_km1      (fll_i_km1),
    .fll_q_km1      (fll_q_km1),
    .fll_iq_k       (fll_iq_k),
    .fll_iq_km1     (fll_iq_km1),
    .fll_wdf_k      (fll_wdf_k),
    .fll_wdfdot_k   (fll_wdfdot_k),
    .fll_done       (fll_done),
    .fll_done_tag   (fll_done_tag),
    .fll_dinc       (fll_dinc),
    .fll_wdf_kp1    (fll_wdf_kp1),
    .fll_wdfdot_kp1 (fll_wdfdot_kp1),
    .dop_valid      (dop_valid),
    .dop_tag        (dop_tag),
    .dop_inc        (dop_inc),
    .overrun        (overrun),
    .timeout_err    (timeout_err)
  );

  // Inputs change 1 time unit after the rising edge; outputs are observed there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic dump(input logic [1:0] tag, input logic [15:0] i, input logic [15:0] q,
                      input logic [16:0] iq);
    acc_valid = 1'b1;
    acc_tag   = tag;
    acc_i     = i;
    acc_q     = q;
    acc_iq    = iq;
    tick();
    acc_valid = 1'b0;
  endtask

  task automatic seed(input logic [1:0] tag, input logic [19:0] wdf);
    seed_valid = 1'b1;
    seed_tag   = tag;
    seed_wdf   = wdf;
    tick();
    seed_valid = 1'b0;
  endtask

  // Waits (bounded) for a dispatch, checks its tag, then steps into WAIT.
  task automatic wait_start(input logic [1:0] tag, input string name);
    int n = 0;
    while (fll_start !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_start"}, 32'(fll_start), 32'd1);
    chk({name, "_tag"}, 32'(fll_tag), 32'(tag));
    tick();
    chk({name, "_pulse_end"}, 32'(fll_start), 32'd0);
  endtask

  task automatic answer(input logic [1:0] tag, input logic [23:0] dinc, input logic [19:0] wdf,
                        input logic [15:0] wdfdot, input string name);
    fll_done       = 1'b1;
    fll_done_tag   = tag;
    fll_dinc       = dinc;
    fll_wdf_kp1    = wdf;
    fll_wdfdot_kp1 = wdfdot;
    tick();
    fll_done = 1'b0;
    chk({name, "_dop_valid"}, 32'(dop_valid), 32'd1);
    chk({name, "_dop_tag"}, 32'(dop_tag), 32'(tag));
    chk({name, "_dop_inc"}, 32'(dop_inc), 32'(dinc));
    tick();
    chk({name, "_dop_pulse_end"}, 32'(dop_valid), 32'd0);
  endtask

  initial begin
    logic seen;

    reset = 1'b1;
    acc_valid = 1'b0; acc_tag = '0; acc_i = '0; acc_q = '0; acc_iq = '0;
    seed_valid = 1'b0; seed_tag = '0; seed_wdf = '0;
    fll_done = 1'b0; fll_done_tag = '0; fll_dinc = '0; fll_wdf_kp1 = '0; fll_wdfdot_kp1 = '0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_fll_start", 32'(fll_start), 32'd0);
    chk("rst_fll_tag", 32'(fll_tag), 32'd0);
    chk("rst_dop_valid", 32'(dop_valid), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);

    // ch2: two dumps -> one dispatch with both periods. -50=0xFFCE, -40=0xFFD8.
    dump(2'd2, 16'd100, 16'hFFCE, 17'd112);
    dump(2'd2, 16'd90, 16'hFFD8, 17'd98);
    chk("t1_no_early_start", 32'(fll_start), 32'd0);
    wait_start(2'd2, "t1");
    chk("t1_i_km1", 32'(fll_i_km1), 32'd100);
    chk("t1_i_k", 32'(fll_i_k), 32'd90);
    chk("t1_q_km1", 32'(fll_q_km1), 32'hFFCE);
    chk("t1_q_k", 32'(fll_q_k), 32'hFFD8);
    chk("t1_iq_km1", 32'(fll_iq_km1), 32'd112);
    chk("t1_iq_k", 32'(fll_iq_k), 32'd98);
    chk("t1_wdf_k", 32'(fll_wdf_k), 32'd0);
    answer(2'd2, 24'h123456, 20'd5000, 16'd7, "t1");

    // ch1 seeded: first dump only fills history, second dispatches with seeded wdf.
    seed(2'd1, 20'd1000);
    dump(2'd1, 16'd5, 16'd50, 17'd51);
    seen = 1'b0;
    for (int n = 0; n < 6; n++) begin
      if (fll_start === 1'b1) seen = 1'b1;
      tick();
    end
    chk("t2_no_dispatch_first_dump", 32'(seen), 32'd0);
    dump(2'd1, 16'd6, 16'd60, 17'd61);
    wait_start(2'd1, "t2");
    chk("t2_wdf_k", 32'(fll_wdf_k), 32'd1000);
    chk("t2_wdfdot_k", 32'(fll_wdfdot_k), 32'd0);
    chk("t2_i_km1", 32'(fll_i_km1), 32'd5);
    chk("t2_i_k", 32'(fll_i_k), 32'd6);
    answer(2'd1, 24'h000111, 20'd1100, 16'd4, "t2");

    // Prime ch0 and ch3, then dumps ch0, ch1, ch3 on consecutive cycles.
    dump(2'd0, 16'd10, 16'd1, 17'd11);
    dump(2'd3, 16'd40, 16'd2, 17'd41);
    acc_valid = 1'b1; acc_tag = 2'd0; acc_i = 16'd11; acc_q = 16'd3; acc_iq = 17'd12;
    tick();
    acc_tag = 2'd1; acc_i = 16'd31; acc_q = 16'd4; acc_iq = 17'd32;
    tick();
    chk("t3_first_start", 32'(fll_start), 32'd1);
    chk("t3_first_tag", 32'(fll_tag), 32'd0);
    chk("t3_ch0_i_k", 32'(fll_i_k), 32'd11);
    chk("t3_ch0_i_km1", 32'(fll_i_km1), 32'd10);
    acc_tag = 2'd3; acc_i = 16'd41; acc_q = 16'd5; acc_iq = 17'd42;
    tick();
    acc_valid = 1'b0;
    // Answer for ch3 while ch0 is in flight must be ignored.
    fll_done = 1'b1; fll_done_tag = 2'd3; fll_dinc = 24'h777777;
    tick();
    fll_done = 1'b0;
    chk("t3_wrong_tag_ignored", 32'(dop_valid), 32'd0);
    chk("t3_no_redispatch", 32'(fll_start), 32'd0);
    // -2000 in 20 bits = 0xFF830, -3 in 16 bits = 0xFFFD.
    answer(2'd0, 24'h00ABCD, 20'hFF830, 16'hFFFD, "t3_ch0");
    wait_start(2'd1, "t3_ch1");
    chk("t3_ch1_wdf_k", 32'(fll_wdf_k), 32'd1100);
    chk("t3_ch1_wdfdot_k", 32'(fll_wdfdot_k), 32'd4);
    chk("t3_ch1_i_km1", 32'(fll_i_km1), 32'd6);
    chk("t3_ch1_i_k", 32'(fll_i_k), 32'd31);
    answer(2'd1, 24'h000222, 20'd1200, 16'd5, "t3_ch1");
    wait_start(2'd3, "t3_ch3");
    chk("t3_ch3_i_km1", 32'(fll_i_km1), 32'd40);
    chk("t3_ch3_i_k", 32'(fll_i_k), 32'd41);
    answer(2'd3, 24'h000333, 20'd300, 16'd1, "t3_ch3");

    // Overrun: ch0 dumped twice while queued behind ch2.
    chk("t4_overrun_clear", 32'(overrun), 32'd0);
    dump(2'd2, 16'd80, 16'd8, 17'd81);
    wait_start(2'd2, "t4_ch2");
    dump(2'd0, 16'd21, 16'd7, 17'd22);
    dump(2'd0, 16'd22, 16'd9, 17'd23);
    chk("t4_overrun_set", 32'(overrun), 32'd1);
    answer(2'd2, 24'h000444, 20'd5100, 16'd8, "t4_ch2");
    wait_start(2'd0, "t4_ch0");
    chk("t4_ch0_i_km1", 32'(fll_i_km1), 32'd21);
    chk("t4_ch0_i_k", 32'(fll_i_k), 32'd22);
    chk("t4_ch0_wdf_k", 32'(fll_wdf_k), 32'hFF830);
    chk("t4_ch0_wdfdot_k", 32'(fll_wdfdot_k), 32'hFFFD);
    answer(2'd0, 24'h000555, 20'd2, 16'd2, "t4_ch0");
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (fll_start === 1'b1) seen = 1'b1;
      tick();
    end
    chk("t4_single_dispatch", 32'(seen), 32'd0);

    // Reseed during WAIT suppresses the writeback and dop pulse.
    dump(2'd1, 16'd7, 16'd1, 17'd8);
    wait_start(2'd1, "t5");
    seed(2'd1, 20'd777);
    fll_done = 1'b1; fll_done_tag = 2'd1; fll_dinc = 24'h0000EE;
    fll_wdf_kp1 = 20'd9999; fll_wdfdot_kp1 = 16'd99;
    tick();
    fll_done = 1'b0;
    chk("t5_suppressed_dop", 32'(dop_valid), 32'd0);
    tick();
    dump(2'd1, 16'd8, 16'd1, 17'd9);
    dump(2'd1, 16'd9, 16'd1, 17'd10);
    wait_start(2'd1, "t5_after_seed");
    chk("t5_wdf_k", 32'(fll_wdf_k), 32'd777);
    chk("t5_wdfdot_k", 32'(fll_wdfdot_k), 32'd0);
    chk("t5_i_km1", 32'(fll_i_km1), 32'd8);

    // No answer: 1024 WAIT cycles before abort (one already spent in wait_start).
    seen = 1'b0;
    for (int n = 0; n < 1023; n++) begin
      if (dop_valid === 1'b1) seen = 1'b1;
      tick();
    end
    chk("t6_timeout_not_early", 32'(timeout_err), 32'd0);
    tick();
    chk("t6_timeout_set", 32'(timeout_err), 32'd1);
    chk("t6_no_dop", 32'(seen | dop_valid), 32'd0);
    dump(2'd1, 16'd10, 16'd1, 17'd11);
    wait_start(2'd1, "t6_idle_again");
    chk("t6_no_writeback", 32'(fll_wdf_k), 32'd777);

    // Reset in the middle of WAIT.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t7_fll_start", 32'(fll_start), 32'd0);
    chk("t7_fll_tag", 32'(fll_tag), 32'd0);
    chk("t7_fll_i_k", 32'(fll_i_k), 32'd0);
    chk("t7_fll_wdf_k", 32'(fll_wdf_k), 32'd0);
    chk("t7_dop_inc", 32'(dop_inc), 32'd0);
    chk("t7_dop_valid", 32'(dop_valid), 32'd0);
    chk("t7_overrun", 32'(overrun), 32'd0);
    chk("t7_timeout", 32'(timeout_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
